// File: rtl/pc_seq_pkg.sv
// Shared types, default constants and address helpers for the pc_sequencer fetch-PC block.
package pc_seq_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_STEP      = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

  // Helpers work on a wide container so any WIDTH up to this fits.
  localparam int unsigned ADDR_MAX = 64;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    STALL_PEND
  } pc_state_e;

  // Which source feeds the PC register at the coming edge.
  typedef enum logic [2:0] {
    SrcInc,
    SrcHold,
    SrcExc,
    SrcRedir,
    SrcPend
  } pc_src_e;

  function automatic logic [ADDR_MAX-1:0] align_addr(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned         step);
    logic [ADDR_MAX-1:0] mask;
    mask = ADDR_MAX'(step) - ADDR_MAX'(1);
    return addr & ~mask;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_MAX-1:0] addr,
                                         input int unsigned         step);
    logic [ADDR_MAX-1:0] mask;
    mask = ADDR_MAX'(step) - ADDR_MAX'(1);
    return (addr & mask) != '0;
  endfunction

endpackage

// File: rtl/pc_pending_buf.sv
// Holds a redirect target that arrived while fetch was frozen, plus its valid flag.
module pc_pending_buf
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pend_target,
  output logic             pending
);

  logic [WIDTH-1:0] target_q;
  logic             pending_q;

  // Clear wins so an exception always discards a buffered redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q  <= '0;
      pending_q <= 1'b0;
    end else if (clear) begin
      pending_q <= 1'b0;
    end else if (load) begin
      target_q  <= target;
      pending_q <= 1'b1;
    end
  end

  assign pend_target = target_q;
  assign pending     = pending_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: increment, redirect, exception vectoring, frozen-redirect buffer.
// Define PC_SEQ_ALIGN_CHECK_EN to force-align accepted targets and pulse misalign.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      STEP      = DEF_STEP,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] epc,
  output logic             pending,
  output logic             misalign
);

  pc_state_e        state_q, state_d;
  pc_src_e          src;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] pend_target;
  logic             buf_load;
  logic             buf_clear;

  function automatic logic [WIDTH-1:0] fix_target(input logic [WIDTH-1:0] t);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    return WIDTH'(align_addr(ADDR_MAX'(t), STEP));
`else
    return t;
`endif
  endfunction

  pc_pending_buf #(
    .WIDTH(WIDTH)
  ) u_pend_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .target     (redirect_target),
    .pend_target(pend_target),
    .pending    (pending)
  );

  // Priority decode. Testing freeze == 0 for the advance path means an unknown freeze holds.
  always_comb begin
    src       = SrcInc;
    state_d   = RUN;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (exc_valid) begin
      src       = SrcExc;
      buf_clear = 1'b1;
    end else if (freeze == 1'b0) begin
      buf_clear = 1'b1;
      if (redirect_valid) begin
        src = SrcRedir;
      end else if (pending) begin
        src = SrcPend;
      end else begin
        src = SrcInc;
      end
    end else begin
      src = SrcHold;
      if (redirect_valid) begin
        buf_load = 1'b1;
        state_d  = STALL_PEND;
      end else if (state_q == STALL_PEND) begin
        state_d = STALL_PEND;
      end else begin
        state_d = STALL;
      end
    end
  end

  always_comb begin
    pc_next = pc_q + WIDTH'(STEP);
    unique case (src)
      SrcHold:  pc_next = pc_q;
      SrcExc:   pc_next = EXC_VEC;
      SrcRedir: pc_next = fix_target(redirect_target);
      SrcPend:  pc_next = fix_target(pend_target);
      default:  pc_next = pc_q + WIDTH'(STEP);
    endcase
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  // Checked on the target actually loaded, not when it was buffered.
  always_comb begin
    misalign_d = 1'b0;
    if (src == SrcRedir) begin
      misalign_d = is_misaligned(ADDR_MAX'(redirect_target), STEP);
    end else if (src == SrcPend) begin
      misalign_d = is_misaligned(ADDR_MAX'(pend_target), STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_next;
      if (src == SrcExc) begin
        epc_q <= pc_q;
      end
    end
  end

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined MIPS fetch stage. It is the next generation of the plain PC register and adds:
- an asynchronous reset to a configurable vector;
- sequential increment;
- branch/jump redirect;
- exception vectoring with EPC capture;
- a pending-redirect buffer, so a redirect arriving during a freeze is not lost.

It sits between the hazard/branch units and instruction-memory addressing.

## Interface
Parameters:
- WIDTH, 32, PC/address width in bits
- STEP, 4, sequential increment in bytes; power of two
- RESET_VEC, 32'h0000_0000, PC value after reset
- EXC_VEC, 32'h8000_0180, exception handler address

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- freeze  in  1  stall from hazard unit; 1 = hold PC
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  WIDTH  redirect destination
- exc_valid  in  1  exception request; overrides freeze
- pc  out  WIDTH  current fetch address (registered)
- pc_next  out  WIDTH  combinational preview of value loaded at next edge
- epc  out  WIDTH  PC at which the last exception was taken (registered)
- pending  out  1  a buffered redirect is waiting (registered)
- misalign  out  1  one-cycle pulse for an accepted misaligned target (see Configuration)

## Operation
Reset (async, immediate):
- pc = RESET_VEC, epc = 0, pending = 0, misalign = 0, state = RUN.

Each rising edge evaluates the following in strict priority order:
1. exc_valid=1: epc <= pc; pc <= EXC_VEC; pending cleared; state <= RUN. This applies even with freeze=1, and any incoming redirect is dropped.
2. freeze=1, redirect_valid=1: pc held; pend_target <= redirect_target; pending <= 1; state <= STALL_PEND. A later redirect during the same freeze overwrites pend_target (youngest wins).
3. freeze=1, redirect_valid=0: pc held; state <= STALL, or stays in STALL_PEND if a redirect is already buffered.
4. freeze=0, redirect_valid=1: pc <= redirect_target. The new redirect beats the buffered one. pending cleared; state <= RUN.
5. freeze=0, pending=1: pc <= pend_target; pending cleared; state <= RUN.
6. Otherwise: pc <= pc + STEP, modulo 2^WIDTH. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.

FSM states:
- RUN to STALL: freeze=1 without redirect.
- RUN or STALL to STALL_PEND: freeze=1 with redirect.
- STALL or STALL_PEND to RUN: freeze=0 or exc_valid.

pc_next is the combinational result of the same priority evaluation; it equals pc while frozen.

Inputs are treated as 2-state. An X on freeze counts as 1 (hold), so an unresolved stall never advances the PC.

## Timing
- Latency: one edge from inputs to pc.
- Redirect buffered during a freeze appears on pc at the first edge where freeze=0.
- Releasing freeze costs no extra cycle.
- pc_next is valid combinationally within the same cycle as its inputs.
- Reset asserted mid-stall discards pend_target; pending reads 0 immediately.
- Simultaneous exc_valid + freeze + redirect_valid: the exception is taken; nothing is buffered.

## Configuration
PC_SEQ_ALIGN_CHECK_EN:
- Defined: any accepted target (redirect or pend_target) with nonzero low log2(STEP) bits is force-aligned (low bits cleared). misalign pulses high for the one cycle after the load. Checking happens at load time, not at buffering time.
- Undefined: targets pass through unmodified and misalign is tied 0. The port list is identical in both builds.

## Structure
- Package pc_seq_pkg holds:
  - the state enum {RUN, STALL, STALL_PEND};
  - default constants for WIDTH, STEP, RESET_VEC, EXC_VEC;
  - a helper function align_addr(addr, step).
- One sub-module, pc_pending_buf, holds pend_target plus the pending flag (load, clear, async reset). The priority mux and FSM stay in pc_sequencer.

## Test plan
- Reset released, freeze=0, 4 cycles -> pc = 0x0, 0x4, 0x8, 0xC, 0x10; pending=0.
- freeze=1 for 3 cycles, redirect 0x1000_0040 in the 2nd frozen cycle -> pc holds, pending=1; first unfrozen edge gives pc=0x1000_0040, pending=0.
- Two redirects while frozen (0x100, then 0x200), then release -> pc=0x200. Release with a new redirect 0x300 while 0x200 is pending -> pc=0x300.
- pc=0x0000_0020, exc_valid with freeze=1 and redirect 0x500 -> pc=0x8000_0180, epc=0x20, pending=0.
- pc=0xFFFF_FFFC, free run -> pc=0x0000_0000. Assert reset mid-cycle during STALL_PEND -> pc=RESET_VEC and pending=0 without waiting for a clock edge.
- With PC_SEQ_ALIGN_CHECK_EN, redirect 0x0000_0102 -> pc=0x0000_0100, one-cycle misalign pulse. Without the macro -> pc=0x0000_0102, misalign=0.
